// File: rtl/ivadd_arb.sv
// Two-requester round-robin front end for a single shared packed add/sub unit
// (4x8 or 2x16 lanes, modulo / unsigned / signed saturation) with a one-deep result register.
module ivadd_arb #(
  parameter int TAGW = 4
) (
  input  logic            cpu_clock_i,
  input  logic            cpu_reset_i,
  input  logic            flush_i,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [31:0]     req0_a_i,
  input  logic [31:0]     req0_b_i,
  input  logic [31:0]     req1_a_i,
  input  logic [31:0]     req1_b_i,
  input  logic [2:0]      req0_op_i,
  input  logic [2:0]      req1_op_i,
  input  logic            req0_size_i,
  input  logic            req1_size_i,
  input  logic [TAGW-1:0] req0_tag_i,
  input  logic [TAGW-1:0] req1_tag_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [31:0]     res_data_o,
  output logic [TAGW-1:0] res_tag_o,
  output logic            res_port_o,
  output logic [15:0]     grant_cnt0_o,
  output logic [15:0]     grant_cnt1_o
);

  // Handshake: a requester transfers on a rising edge where req_valid_i[k] & req_ready_o[k];
  // the result transfers on an edge where res_valid_o & res_ready_i. Ready never looks at operands.

  function automatic logic [7:0] lane8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [8:0] r;
    logic       ovf_s;
    r     = op[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf_s = op[0] ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
    lane8 = r[7:0];
    if (op[2]) begin
      if (op[1]) begin
        if (ovf_s) lane8 = a[7] ? 8'h80 : 8'h7F;
      end else if (r[8]) begin
        lane8 = op[0] ? 8'h00 : 8'hFF;
      end
    end
  endfunction

  function automatic logic [15:0] lane16(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    logic [16:0] r;
    logic        ovf_s;
    r      = op[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf_s  = op[0] ? ((a[15] != b[15]) && (r[15] != a[15])) : ((a[15] == b[15]) && (r[15] != a[15]));
    lane16 = r[15:0];
    if (op[2]) begin
      if (op[1]) begin
        if (ovf_s) lane16 = a[15] ? 16'h8000 : 16'h7FFF;
      end else if (r[16]) begin
        lane16 = op[0] ? 16'h0000 : 16'hFFFF;
      end
    end
  endfunction

  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic [TAGW-1:0] res_tag_q, res_tag_d;
  logic            res_port_q, res_port_d;
  logic            last_grant_q, last_grant_d;
  logic [15:0]     cnt0_q, cnt0_d;
  logic [15:0]     cnt1_q, cnt1_d;

  logic            accept_ok;
  logic            gnt_sel;
  logic            accept;
  logic [31:0]     op_a, op_b;
  logic [2:0]      op_op;
  logic            op_size;
  logic [31:0]     alu_res;

  always_comb begin
    accept_ok = !cpu_reset_i && !flush_i && (!res_valid_q || res_ready_i);
    gnt_sel   = 1'b0;
    if (req_valid_i == 2'b11) gnt_sel = ~last_grant_q;
    else if (req_valid_i[1])  gnt_sel = 1'b1;
    req_ready_o = 2'b00;
    if (accept_ok && (req_valid_i != 2'b00)) req_ready_o = gnt_sel ? 2'b10 : 2'b01;
    accept = |(req_valid_i & req_ready_o);
  end

  always_comb begin
    op_a    = gnt_sel ? req1_a_i : req0_a_i;
    op_b    = gnt_sel ? req1_b_i : req0_b_i;
    op_op   = gnt_sel ? req1_op_i : req0_op_i;
    op_size = gnt_sel ? req1_size_i : req0_size_i;
    if (op_size) begin
      alu_res = {lane16(op_a[31:16], op_b[31:16], op_op), lane16(op_a[15:0], op_b[15:0], op_op)};
    end else begin
      alu_res = {lane8(op_a[31:24], op_b[31:24], op_op), lane8(op_a[23:16], op_b[23:16], op_op),
                 lane8(op_a[15:8], op_b[15:8], op_op), lane8(op_a[7:0], op_b[7:0], op_op)};
    end
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_port_d   = res_port_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (flush_i) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d  = 1'b1;
      res_data_d   = alu_res;
      res_tag_d    = gnt_sel ? req1_tag_i : req0_tag_i;
      res_port_d   = gnt_sel;
      last_grant_d = gnt_sel;
      if (gnt_sel) cnt1_d = cnt1_q + 16'd1;
      else         cnt0_d = cnt0_q + 16'd1;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      res_port_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_port_q   <= res_port_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_tag_o    = res_tag_q;
  assign res_port_o   = res_port_q;
  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;

endmodule

// File: doc/ivadd_arb.md
IVADD_ARB -- requirements
Module: ivadd_arb

Interface
REQ-001 SHALL have parameter TAGW, default 4, width of the requester tag carried alongside each operation.
REQ-002 SHALL have port cpu_clock_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_reset_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush_i  input  1  pipeline flush; discards the held result.
REQ-005 SHALL have ports req_valid_i  input  2, and req_ready_o  output  2; bit k belongs to requester k.
REQ-006 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  32  packed operands.
REQ-007 SHALL have ports req0_op_i, req1_op_i  input  3: bit0 subtract, bit1 signed saturation, bit2 saturating.
REQ-008 SHALL have ports req0_size_i, req1_size_i  input  1: 0 = four 8-bit lanes, 1 = two 16-bit lanes.
REQ-009 SHALL have ports req0_tag_i, req1_tag_i  input  TAGW  opaque tag.
REQ-010 SHALL have ports res_valid_o  output  1, res_ready_i  input  1, res_data_o  output  32, res_tag_o  output  TAGW, res_port_o  output  1.
REQ-011 SHALL have ports grant_cnt0_o, grant_cnt1_o  output  16  accepted-operation counters per requester.

Function
REQ-012 Single shared packed add/sub unit; exactly one operation enters it per cycle at most.
REQ-013 Stage may accept when (!res_valid_o | res_ready_i) & !flush_i; otherwise req_ready_o = 2'b00.
REQ-014 req_ready_o one-hot or zero; only the granted requester sees ready; handshake = valid & ready on same edge.
REQ-015 Grant: one valid requester -> it wins; both valid -> requester other than last_grant wins (round-robin).
REQ-016 last_grant updates only on an accepted handshake; unchanged on stall, flush or idle cycles.
REQ-017 req_ready_o is a combinational function of req_valid_i, res_valid_o, res_ready_i, flush_i and last_grant; it SHALL NOT depend on operand values.
REQ-018 Latency 1: operation accepted at edge N -> res_valid_o=1 with result, tag and port visible after edge N.
REQ-019 res_valid_o=1 & res_ready_i=0 -> res_data_o/res_tag_o/res_port_o held stable until consumed.
REQ-020 Consume and accept on the same edge -> new result replaces old; res_valid_o stays 1 (no bubble).
REQ-021 Consume with no accept -> res_valid_o=0 next cycle.
REQ-022 Lane arithmetic: op[0]=0 a+b, op[0]=1 a-b, per lane, no carry across lanes of the selected size.
REQ-023 op[2]=0 -> modulo-lane-width result.
REQ-024 op[2]=1, op[1]=0 -> unsigned clamp: add overflow -> all-ones lane, sub underflow -> zero lane.
REQ-025 op[2]=1, op[1]=1 -> signed clamp: positive overflow -> 0x7F/0x7FFF, negative overflow -> 0x80/0x8000.
REQ-026 op=3'b010 or 3'b011 (signed without saturate) SHALL behave as op[1]=0.
REQ-027 Counters: grant_cntk_o increments by 1 per accepted handshake of requester k; wraps 0xFFFF -> 0x0000.
REQ-028 flush_i=1: res_valid_o=0 next cycle regardless of res_ready_i; no grant that cycle; counters and last_grant unchanged.
REQ-029 Requester dropping valid before grant SHALL be legal; no state change.

Reset
REQ-030 cpu_reset_i=1 at an edge: res_valid_o=0, res_data_o=0, res_tag_o=0, res_port_o=0, grant counters 0, last_grant=1 (requester 0 wins first tie).
REQ-031 During reset cycle req_ready_o=2'b00; reset dominates flush_i and any in-progress handshake.

Verification
REQ-032 Req0 only, a=0x01020304 b=0x01010101 op=000 size=0 tag=3 -> next cycle res_valid_o=1, data 0x02030405, tag 3, port 0, grant_cnt0_o=1.
REQ-033 op=100 size=0 a=0xF0000001 b=0x20000001 -> data 0xFF000002.
REQ-034 op=111 size=1 a=0x80000005 b=0x00010003 -> data 0x80000002.
REQ-035 Both valid continuously, res_ready_i=1, after reset -> grants 0,1,0,1; res_port_o alternates; each counter +1 per two cycles.
REQ-036 res_ready_i=0 with result held, both requesting -> req_ready_o=00, outputs stable 5 cycles; raise ready -> consume and accept same edge, no bubble.
REQ-037 flush_i pulse while res_valid_o=1 and both requesting -> res_valid_o=0 next cycle, no grant, counters unchanged; reset mid-stall -> all REQ-030 values.
